// File: rtl/prod_accum.sv
// Burst accumulator for multiplier products: sums `len` products over a valid/ready
// handshake into a wrap-around register, then offers the sum on a second handshake.
module prod_accum #(
  parameter int unsigned PW = 8,
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic [PW-1:0] prod_in,
  input  logic          prod_valid,
  output logic          prod_ready,
  output logic [AW-1:0] sum_out,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e        state;
  logic [CW-1:0] remaining;
  logic [AW:0]   add_res;

  // sum_out doubles as the accumulator; the extra top bit is the carry-out.
  assign add_res = {1'b0, sum_out} + {{(AW + 1 - PW){1'b0}}, prod_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      remaining  <= '0;
      sum_out    <= '0;
      overflow   <= 1'b0;
      sum_valid  <= 1'b0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            sum_out  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (len == '0) begin
              state     <= StDone;
              sum_valid <= 1'b1;
            end else begin
              state      <= StAccum;
              remaining  <= len;
              prod_ready <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (prod_valid && prod_ready) begin
            sum_out   <= add_res[AW-1:0];
            overflow  <= overflow | add_res[AW];
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state      <= StDone;
              prod_ready <= 1'b0;
              sum_valid  <= 1'b1;
            end
          end
        end
        StDone: begin
          // A start arriving with the handshake is dropped: start is only seen in idle.
          if (sum_ready) begin
            state     <= StIdle;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= StIdle;
          sum_valid  <= 1'b0;
          prod_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed self-checking bench for prod_accum; a second instance with AW=11 covers wrap/overflow.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst, start, prod_valid, sum_ready;
  logic [3:0]  len;
  logic [7:0]  prod_in;
  logic        prod_ready, sum_valid, overflow, busy;
  logic [11:0] sum_out;
  logic        prod_ready11, sum_valid11, overflow11, busy11;
  logic [10:0] sum_out11;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  prod_accum #(.PW(8), .AW(12), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .sum_out(sum_out),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .overflow(overflow), .busy(busy)
  );

  prod_accum #(.PW(8), .AW(11), .CW(4)) dut11 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready11), .sum_out(sum_out11),
    .sum_valid(sum_valid11), .sum_ready(sum_ready), .overflow(overflow11), .busy(busy11)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held two cycles with busy-looking inputs, including start.
    rst = 1'b1; start = 1'b1; len = 4'd5; prod_valid = 1'b1;
    prod_in = 8'($urandom); sum_ready = 1'b1;
    tick();
    prod_in = 8'($urandom);
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_prod_ready", 32'(prod_ready), 0);
    check("rst_sum_valid", 32'(sum_valid), 0);
    check("rst_sum_out", 32'(sum_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0; sum_ready = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Basic burst: 225 + 10 + 6 = 241.
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    check("basic_busy", 32'(busy), 1);
    prod_valid = 1'b1;
    prod_in = 8'd225; check("basic_rdy0", 32'(prod_ready), 1); tick();
    prod_in = 8'd10;  check("basic_rdy1", 32'(prod_ready), 1); tick();
    check("basic_sv_early", 32'(sum_valid), 0);
    prod_in = 8'd6;   check("basic_rdy2", 32'(prod_ready), 1); tick();
    prod_valid = 1'b0;
    check("basic_sum_valid", 32'(sum_valid), 1);
    check("basic_sum_out", 32'(sum_out), 241);
    check("basic_overflow", 32'(overflow), 0);
    check("basic_rdy_done", 32'(prod_ready), 0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("basic_idle_sv", 32'(sum_valid), 0);
    check("basic_idle_busy", 32'(busy), 0);
    check("basic_idle_hold", 32'(sum_out), 241);

    // Handshake stress: valid pattern 0,1,0,0,1 carrying 9 then 4.
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    prod_valid = 1'b0; prod_in = 8'd77;  tick();
    prod_valid = 1'b1; prod_in = 8'd9;   tick();
    prod_valid = 1'b0; prod_in = 8'd100; tick();
    prod_valid = 1'b0; prod_in = 8'd50;  tick();
    check("hs_not_done", 32'(sum_valid), 0);
    prod_valid = 1'b1; prod_in = 8'd4;   tick();
    check("hs_sum_valid", 32'(sum_valid), 1);
    check("hs_sum_out", 32'(sum_out), 13);
    // Extra valid products while waiting must not be absorbed.
    prod_in = 8'd33;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hs_hold_valid", 32'(sum_valid), 1);
      check("hs_hold_sum", 32'(sum_out), 13);
    end
    prod_valid = 1'b0;
    sum_ready = 1'b1; start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0; sum_ready = 1'b0;
    check("hs_idle_busy", 32'(busy), 0);
    check("hs_idle_sv", 32'(sum_valid), 0);
    check("hs_start_dropped", 32'(prod_ready), 0);
    tick();
    check("hs_still_idle", 32'(busy), 0);

    // Zero length.
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    check("zero_sum_valid", 32'(sum_valid), 1);
    check("zero_sum_out", 32'(sum_out), 0);
    check("zero_prod_ready", 32'(prod_ready), 0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("zero_idle_busy", 32'(busy), 0);
    check("zero_prod_ready2", 32'(prod_ready), 0);

    // Wrap: 15 x 225 = 3375, which is 1327 mod 2048 with a carry at AW=11.
    start = 1'b1; len = 4'd15;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod_in = 8'd225;
    for (int i = 0; i < 15; i++) tick();
    prod_valid = 1'b0;
    check("wrap_sum_valid11", 32'(sum_valid11), 1);
    check("wrap_sum_out11", 32'(sum_out11), 1327);
    check("wrap_overflow11", 32'(overflow11), 1);
    check("wrap_sum_out12", 32'(sum_out), 3375);
    check("wrap_overflow12", 32'(overflow), 0);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("wrap_ovf_sticky_idle", 32'(overflow11), 1);
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    check("wrap_ovf_cleared", 32'(overflow11), 0);
    prod_valid = 1'b1; prod_in = 8'd1;
    tick();
    prod_valid = 1'b0;
    check("next_sum_out11", 32'(sum_out11), 1);
    check("next_overflow11", 32'(overflow11), 0);
    check("next_sum_valid11", 32'(sum_valid11), 1);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;

    // Reset mid-burst after two of four transfers.
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_in = 8'd20; tick();
    prod_in = 8'd30; tick();
    prod_valid = 1'b0;
    check("mid_sum_part", 32'(sum_out), 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", 32'(busy), 0);
    check("mid_prod_ready", 32'(prod_ready), 0);
    check("mid_sum_valid", 32'(sum_valid), 0);
    prod_valid = 1'b1; prod_in = 8'd40;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_sum_valid", 32'(sum_valid), 0);
    end
    prod_valid = 1'b0;
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    prod_valid = 1'b1; prod_in = 8'd9;
    tick();
    prod_valid = 1'b0;
    check("post_sum_valid", 32'(sum_valid), 1);
    check("post_sum_out", 32'(sum_out), 9);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("post_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
